// File: rtl/apb_ucpd_tx_seq_if.sv
// Control and status bundle between a host and the UCPD transmit sequencer.
// The host drives the request side and the sequencer drives phase and status outputs.
interface apb_ucpd_tx_seq_if #(
    parameter int PAY_W = 10
);
    logic             tx_start;
    logic [1:0]       tx_mode;
    logic [PAY_W-1:0] tx_paysize;
    logic [7:0]       ifg_bits;
    logic [15:0]      bist_bits;
    logic             tx_abort;
    logic             txfifo_empty;
    logic             txfifo_ld_en;
    logic             pre_en;
    logic             sop_en;
    logic             data_en;
    logic             crc_en;
    logic             eop_en;
    logic             wait_en;
    logic             bist_en;
    logic             bmc_en;
    logic             cc_oen;
    logic [3:0]       bit_idx;
    logic             tx_busy;
    logic             tx_msg_sent;
    logic             tx_msg_abt;
    logic             tx_und;
    logic             tx_rst_sent;

    modport master (
        output tx_start, tx_mode, tx_paysize, ifg_bits, bist_bits, tx_abort, txfifo_empty,
        input  txfifo_ld_en, pre_en, sop_en, data_en, crc_en, eop_en, wait_en, bist_en,
        input  bmc_en, cc_oen, bit_idx, tx_busy, tx_msg_sent, tx_msg_abt, tx_und, tx_rst_sent
    );

    modport slave (
        input  tx_start, tx_mode, tx_paysize, ifg_bits, bist_bits, tx_abort, txfifo_empty,
        output txfifo_ld_en, pre_en, sop_en, data_en, crc_en, eop_en, wait_en, bist_en,
        output bmc_en, cc_oen, bit_idx, tx_busy, tx_msg_sent, tx_msg_abt, tx_und, tx_rst_sent
    );
endinterface

// File: rtl/apb_ucpd_tx_seq.sv
// USB-PD transmit sequencer: preamble, SOP, payload, CRC, EOP and inter-frame gap.
// Define UCPD_TX_BIST_EN to enable the BIST carrier mode (tx_mode 3).
module apb_ucpd_tx_seq #(
    parameter int PRE_BITS  = 64,
    parameter int SOP_BITS  = 20,
    parameter int CRC_BITS  = 40,
    parameter int EOP_BITS  = 5,
    parameter int PAY_W     = 10,
    parameter int BYTE_BITS = 10
) (
    input  logic                   ic_clk,
    input  logic                   ic_rst,
    input  logic                   ucpden,
    input  logic                   bit_tick,
    apb_ucpd_tx_seq_if.slave       bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SOP  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_EOP  = 3'd5,
        ST_WAIT = 3'd6,
        ST_BIST = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [15:0]      bit_cnt_r;
    logic [15:0]      bit_cnt_nxt;
    logic [3:0]       bit_idx_r;
    logic [3:0]       bit_idx_nxt;
    logic [PAY_W-1:0] byte_cnt_r;
    logic [PAY_W-1:0] byte_cnt_nxt;
    logic [PAY_W-1:0] size_r;
    logic [1:0]       mode_r;
    logic             abort_r;
    logic             abort_nxt;
    logic             msg_sent_r;
    logic             msg_abt_r;
    logic             rst_sent_r;
    logic [15:0]      len_m1_s;
    logic             bit_last_s;
    logic             bit_wrap_s;
    logic             byte_last_s;
    logic             start_ok_s;
    logic             ld_en_s;
    logic             und_s;
    logic             latch_s;
    logic             done_s;

`ifdef UCPD_TX_BIST_EN
    assign start_ok_s = 1'b1;
`else
    assign start_ok_s = (bus.tx_mode != 2'd3);
`endif

    // Terminal bit count of the current serial phase.
    always_comb begin
        len_m1_s = 16'd0;
        case (state_r)
            ST_PRE:  len_m1_s = 16'(PRE_BITS - 1);
            ST_SOP:  len_m1_s = 16'(SOP_BITS - 1);
            ST_CRC:  len_m1_s = 16'(CRC_BITS - 1);
            ST_EOP:  len_m1_s = 16'(EOP_BITS - 1);
            ST_WAIT: len_m1_s = (bus.ifg_bits == 8'd0) ? 16'd0 : ({8'd0, bus.ifg_bits} - 16'd1);
`ifdef UCPD_TX_BIST_EN
            ST_BIST: len_m1_s = (bus.bist_bits == 16'd0) ? 16'd0 : (bus.bist_bits - 16'd1);
`endif
            default: len_m1_s = 16'd0;
        endcase
    end

    assign bit_last_s  = bit_tick && (bit_cnt_r == len_m1_s);
    assign bit_wrap_s  = bit_tick && (bit_idx_r == 4'(BYTE_BITS - 1));
    assign byte_last_s = (byte_cnt_r == (size_r - PAY_W'(1)));

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt    = state_r;
        bit_cnt_nxt  = bit_cnt_r;
        bit_idx_nxt  = bit_idx_r;
        byte_cnt_nxt = byte_cnt_r;
        abort_nxt    = abort_r;
        ld_en_s      = 1'b0;
        und_s        = 1'b0;
        latch_s      = 1'b0;
        done_s       = 1'b0;

        if (bit_tick && (state_r != ST_IDLE) && (state_r != ST_DATA)) begin
            bit_cnt_nxt = bit_last_s ? 16'd0 : (bit_cnt_r + 16'd1);
        end else begin
            bit_cnt_nxt = bit_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.tx_start && start_ok_s) begin
                    state_nxt = ST_PRE;
                    latch_s   = 1'b1;
                    abort_nxt = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (bit_last_s) begin
`ifdef UCPD_TX_BIST_EN
                    state_nxt = (mode_r == 2'd3) ? ST_BIST : ST_SOP;
`else
                    state_nxt = ST_SOP;
`endif
                end else begin
                    state_nxt = ST_PRE;
                end
            end
            ST_SOP: begin
                if (!bit_last_s) begin
                    state_nxt = ST_SOP;
                end else if (mode_r != 2'd0) begin
                    state_nxt = ST_WAIT;
                end else if (size_r == '0) begin
                    state_nxt = ST_CRC;
                end else begin
                    // First byte is fetched as the ordered set ends.
                    ld_en_s = 1'b1;
                    if (bus.txfifo_empty) begin
                        und_s     = 1'b1;
                        abort_nxt = 1'b1;
                        state_nxt = ST_EOP;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bus.tx_abort) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_EOP;
                end else if (bit_wrap_s) begin
                    bit_idx_nxt = 4'd0;
                    if (byte_last_s) begin
                        state_nxt = ST_CRC;
                    end else begin
                        ld_en_s      = 1'b1;
                        byte_cnt_nxt = byte_cnt_r + PAY_W'(1);
                        if (bus.txfifo_empty) begin
                            und_s     = 1'b1;
                            abort_nxt = 1'b1;
                            state_nxt = ST_EOP;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                end else if (bit_tick) begin
                    bit_idx_nxt = bit_idx_r + 4'd1;
                end else begin
                    bit_idx_nxt = bit_idx_r;
                end
            end
            ST_CRC: begin
                if (bus.tx_abort) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_EOP;
                end else if (bit_last_s) begin
                    state_nxt = ST_EOP;
                end else begin
                    state_nxt = ST_CRC;
                end
            end
            ST_EOP: begin
                state_nxt = bit_last_s ? ST_WAIT : ST_EOP;
            end
            ST_WAIT: begin
                if ((bus.ifg_bits == 8'd0) || bit_last_s) begin
                    state_nxt = ST_IDLE;
                    done_s    = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
`ifdef UCPD_TX_BIST_EN
            ST_BIST: begin
                state_nxt = (bus.tx_abort || bit_last_s) ? ST_IDLE : ST_BIST;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, latched request and completion pulses.
    always_ff @(posedge ic_clk) begin
        if (ic_rst || !ucpden) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 16'd0;
            bit_idx_r  <= 4'd0;
            byte_cnt_r <= '0;
            size_r     <= '0;
            mode_r     <= 2'd0;
            abort_r    <= 1'b0;
            msg_sent_r <= 1'b0;
            msg_abt_r  <= 1'b0;
            rst_sent_r <= 1'b0;
        end else begin
            // Every phase change restarts the bit and byte counters.
            state_r    <= state_nxt;
            bit_cnt_r  <= (state_nxt != state_r) ? 16'd0 : bit_cnt_nxt;
            bit_idx_r  <= (state_nxt != state_r) ? 4'd0 : bit_idx_nxt;
            byte_cnt_r <= (state_nxt != state_r) ? '0 : byte_cnt_nxt;
            abort_r    <= abort_nxt;
            if (latch_s) begin
                mode_r <= bus.tx_mode;
                size_r <= bus.tx_paysize;
            end else begin
                mode_r <= mode_r;
                size_r <= size_r;
            end
            msg_sent_r <= done_s && (mode_r == 2'd0) && !abort_r;
            msg_abt_r  <= done_s && (mode_r == 2'd0) && abort_r;
            rst_sent_r <= done_s && ((mode_r == 2'd1) || (mode_r == 2'd2));
        end
    end

    assign bus.pre_en  = (state_r == ST_PRE);
    assign bus.sop_en  = (state_r == ST_SOP);
    assign bus.data_en = (state_r == ST_DATA);
    assign bus.crc_en  = (state_r == ST_CRC);
    assign bus.eop_en  = (state_r == ST_EOP);
    assign bus.wait_en = (state_r == ST_WAIT);
`ifdef UCPD_TX_BIST_EN
    assign bus.bist_en = (state_r == ST_BIST);
`else
    assign bus.bist_en = 1'b0;
`endif
    assign bus.bmc_en = bus.pre_en | bus.sop_en | bus.data_en | bus.crc_en |
                        bus.eop_en | bus.bist_en | bus.wait_en;
    assign bus.cc_oen       = bus.bmc_en;
    assign bus.bit_idx      = bit_idx_r;
    assign bus.tx_busy      = (state_r != ST_IDLE);
    assign bus.txfifo_ld_en = ld_en_s & ucpden;
    assign bus.tx_und       = und_s & ucpden;
    assign bus.tx_msg_sent  = msg_sent_r;
    assign bus.tx_msg_abt   = msg_abt_r;
    assign bus.tx_rst_sent  = rst_sent_r;

endmodule

// File: tb/tb_apb_ucpd_tx_seq.sv
// Directed bench for apb_ucpd_tx_seq: counts bit ticks per phase and completion pulses per frame.
module tb_apb_ucpd_tx_seq;

    logic ic_clk = 1'b0;
    logic ic_rst;
    logic ucpden;
    logic bit_tick;

    apb_ucpd_tx_seq_if #(.PAY_W(10)) bus ();

    apb_ucpd_tx_seq dut (
        .ic_clk   (ic_clk),
        .ic_rst   (ic_rst),
        .ucpden   (ucpden),
        .bit_tick (bit_tick),
        .bus      (bus.slave)
    );

    always #5 ic_clk = ~ic_clk;

    int checks   = 0;
    int failures = 0;
    int div      = 0;
    int c_pre, c_sop, c_data, c_crc, c_eop, c_wait, c_bist;
    int c_ld, c_und, c_sent, c_abt, c_rst, c_busy, c_data_cyc, c_wait_cyc;
    int ok;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        c_pre = 0; c_sop = 0; c_data = 0; c_crc = 0; c_eop = 0; c_wait = 0; c_bist = 0;
        c_ld = 0; c_und = 0; c_sent = 0; c_abt = 0; c_rst = 0; c_busy = 0;
        c_data_cyc = 0; c_wait_cyc = 0;
    endtask

    // Sample the current cycle mid-period, then advance one clock and set the next tick.
    task automatic step();
        #1;
        if (bit_tick && bus.pre_en)  c_pre++;
        if (bit_tick && bus.sop_en)  c_sop++;
        if (bit_tick && bus.data_en) c_data++;
        if (bit_tick && bus.crc_en)  c_crc++;
        if (bit_tick && bus.eop_en)  c_eop++;
        if (bit_tick && bus.wait_en) c_wait++;
        if (bit_tick && bus.bist_en) c_bist++;
        if (bus.txfifo_ld_en) c_ld++;
        if (bus.tx_und)       c_und++;
        if (bus.tx_msg_sent)  c_sent++;
        if (bus.tx_msg_abt)   c_abt++;
        if (bus.tx_rst_sent)  c_rst++;
        if (bus.tx_busy)      c_busy++;
        if (bus.data_en)      c_data_cyc++;
        if (bus.wait_en)      c_wait_cyc++;
        @(posedge ic_clk);
        #1;
        div      = (div + 1) % 4;
        bit_tick = (div == 3);
    endtask

    task automatic start_frame(input logic [1:0] mode, input int size, input int ifg);
        clr();
        bus.tx_mode    = mode;
        bus.tx_paysize = 10'(size);
        bus.ifg_bits   = 8'(ifg);
        bus.tx_start   = 1'b1;
        step();
        bus.tx_start   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (!bus.tx_busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, "_done"}, ok, 1);
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        ic_rst           = 1'b1;
        ucpden           = 1'b1;
        bit_tick         = 1'b0;
        bus.tx_start     = 1'b0;
        bus.tx_mode      = 2'd0;
        bus.tx_paysize   = 10'd0;
        bus.ifg_bits     = 8'd0;
        bus.bist_bits    = 16'd100;
        bus.tx_abort     = 1'b0;
        bus.txfifo_empty = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) step();
        ic_rst = 1'b0;
        step();
        chk("rst_busy", int'(bus.tx_busy), 0);
        chk("rst_bmc", int'(bus.bmc_en), 0);
        chk("rst_cc_oen", int'(bus.cc_oen), 0);
        chk("rst_bit_idx", int'(bus.bit_idx), 0);
        chk("rst_pulses", int'(bus.tx_msg_sent) + int'(bus.tx_msg_abt) + int'(bus.tx_rst_sent), 0);

        // Normal message, start coincident with a tick.
        while (!bit_tick) step();
        start_frame(2'd0, 2, 25);
        chk("t1_busy", int'(bus.tx_busy), 1);
        chk("t1_pre_en", int'(bus.pre_en), 1);
        wait_idle("t1");
        chk("t1_pre", c_pre, 64);
        chk("t1_sop", c_sop, 20);
        chk("t1_data", c_data, 20);
        chk("t1_crc", c_crc, 40);
        chk("t1_eop", c_eop, 5);
        chk("t1_wait", c_wait, 25);
        chk("t1_ld", c_ld, 2);
        chk("t1_und", c_und, 0);
        chk("t1_sent", c_sent, 1);
        chk("t1_abt", c_abt, 0);

        // Underrun on the second FIFO load.
        start_frame(2'd0, 3, 25);
        for (int i = 0; i < 4000 && c_ld < 1; i++) step();
        bus.txfifo_empty = 1'b1;
        wait_idle("t2");
        bus.txfifo_empty = 1'b0;
        chk("t2_und", c_und, 1);
        chk("t2_ld", c_ld, 2);
        chk("t2_data", c_data, 10);
        chk("t2_crc", c_crc, 0);
        chk("t2_eop", c_eop, 5);
        chk("t2_abt", c_abt, 1);
        chk("t2_sent", c_sent, 0);

        // Hard reset, with a start request while busy that must be dropped.
        start_frame(2'd1, 2, 10);
        for (int i = 0; i < 4000 && c_sop < 3; i++) step();
        bus.tx_mode  = 2'd0;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        wait_idle("t3");
        chk("t3_pre", c_pre, 64);
        chk("t3_sop", c_sop, 20);
        chk("t3_wait", c_wait, 10);
        chk("t3_data_cyc", c_data_cyc, 0);
        chk("t3_ld", c_ld, 0);
        chk("t3_rst", c_rst, 1);
        chk("t3_sent", c_sent, 0);
        chk("t3_no_restart", int'(bus.tx_busy), 0);

        // Abort at CRC bit 10.
        start_frame(2'd0, 1, 6);
        for (int i = 0; i < 4000 && c_crc < 10; i++) step();
        bus.tx_abort = 1'b1;
        step();
        bus.tx_abort = 1'b0;
        chk("t4_eop_next", int'(bus.eop_en), 1);
        wait_idle("t4");
        chk("t4_crc", c_crc, 10);
        chk("t4_eop", c_eop, 5);
        chk("t4_abt", c_abt, 1);
        chk("t4_sent", c_sent, 0);

        // Abort during preamble has no effect.
        start_frame(2'd0, 1, 6);
        for (int i = 0; i < 4000 && c_pre < 5; i++) step();
        bus.tx_abort = 1'b1;
        step();
        bus.tx_abort = 1'b0;
        wait_idle("t4b");
        chk("t4b_pre", c_pre, 64);
        chk("t4b_crc", c_crc, 40);
        chk("t4b_sent", c_sent, 1);
        chk("t4b_abt", c_abt, 0);

        // Cable reset with zero inter-frame gap.
        start_frame(2'd2, 0, 0);
        wait_idle("t4c");
        chk("t4c_wait_cyc", c_wait_cyc, 1);
        chk("t4c_wait", c_wait, 0);
        chk("t4c_rst", c_rst, 1);

        // Zero-length payload goes straight to CRC.
        start_frame(2'd0, 0, 3);
        wait_idle("t4d");
        chk("t4d_data_cyc", c_data_cyc, 0);
        chk("t4d_ld", c_ld, 0);
        chk("t4d_crc", c_crc, 40);
        chk("t4d_sent", c_sent, 1);

        // Block disable mid-payload, then a clean frame.
        start_frame(2'd0, 2, 8);
        for (int i = 0; i < 4000 && c_data < 5; i++) step();
        ucpden = 1'b0;
        step();
        chk("t5_busy", int'(bus.tx_busy), 0);
        chk("t5_bmc", int'(bus.bmc_en), 0);
        chk("t5_bit_idx", int'(bus.bit_idx), 0);
        chk("t5_ld", int'(bus.txfifo_ld_en), 0);
        for (int i = 0; i < 5; i++) step();
        chk("t5_pulses", c_sent + c_abt + c_rst + c_und, 0);
        ucpden = 1'b1;
        step();
        start_frame(2'd0, 1, 8);
        wait_idle("t5b");
        chk("t5b_pre", c_pre, 64);
        chk("t5b_data", c_data, 10);
        chk("t5b_crc", c_crc, 40);
        chk("t5b_wait", c_wait, 8);
        chk("t5b_ld", c_ld, 1);
        chk("t5b_sent", c_sent, 1);

        // BIST carrier.
        bus.bist_bits = 16'd100;
`ifdef UCPD_TX_BIST_EN
        start_frame(2'd3, 0, 5);
        wait_idle("t6");
        chk("t6_pre", c_pre, 64);
        chk("t6_bist", c_bist, 100);
        chk("t6_sop", c_sop, 0);
        chk("t6_pulses", c_sent + c_abt + c_rst, 0);
`else
        start_frame(2'd3, 0, 5);
        for (int i = 0; i < 20; i++) step();
        chk("t6_busy", c_busy, 0);
        chk("t6_pre", c_pre, 0);
        chk("t6_bist_en", c_bist, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_ucpd_tx_seq.md
Name: apb_ucpd_tx_seq

Overview:
Parametrised USB-PD transmit sequencer, the next generation of the UCPD main TX FSM. It runs preamble, SOP, payload, CRC, EOP and inter-frame gap for normal, hard-reset, cable-reset and (optionally) BIST transmissions. Phase lengths are parameters, and the gap length is a runtime input. It adds FIFO-underrun and software-abort handling with distinct completion pulses, and drives the BMC encoder enables and TX-FIFO load strobe in the ic_clk domain.

Parameters:
PRE_BITS, 64, preamble length in bits
SOP_BITS, 20, ordered-set length in bits (4 K-codes x 5)
CRC_BITS, 40, CRC length in encoded bits (8 symbols x 5)
EOP_BITS, 5, EOP length in bits
PAY_W, 10, width of payload byte-count
BYTE_BITS, 10, encoded bits per payload byte (4b5b)

Ports:
ic_clk  in  1  block clock (HSI16)
ic_rst  in  1  synchronous reset, active-high
ucpden  in  1  block enable; low forces IDLE
bit_tick  in  1  one-cycle pulse per TX bit period
tx_start  in  1  start request; sampled only in IDLE
tx_mode  in  2  0 msg, 1 hard reset, 2 cable reset, 3 BIST
tx_paysize  in  PAY_W  payload bytes incl. header
ifg_bits  in  8  inter-frame gap in bit periods
bist_bits  in  16  BIST carrier length in bits
tx_abort  in  1  software abort of current message
txfifo_empty  in  1  TX FIFO has no byte
txfifo_ld_en  out  1  pulse: load next byte into encoder
pre_en, sop_en, data_en, crc_en, eop_en, wait_en, bist_en  out  1 each  one-hot phase indicators
bmc_en  out  1  OR of pre/sop/data/crc/eop/bist/wait enables
cc_oen  out  1  equals bmc_en
bit_idx  out  4  bit position inside current payload byte
tx_busy  out  1  state != IDLE
tx_msg_sent, tx_msg_abt, tx_und, tx_rst_sent  out  1 each  one-cycle completion pulses

Behaviour:
- Reset / ucpden=0: state IDLE; all counters, latched mode/size and all outputs 0. ucpden=0 mid-frame: IDLE next cycle, no completion pulse.
- States: IDLE, PRE, SOP, DATA, CRC, EOP, WAIT, BIST. Phase enables decode the state register directly (0-cycle latency from state).
- IDLE: tx_start=1 latches tx_mode and tx_paysize and enters PRE next cycle. Mode 3 without the feature: start ignored.
- Phase exit: bit_cnt increments on bit_tick. A phase exits on the bit_tick where bit_cnt == LEN-1. bit_cnt clears on phase exit.
- PRE -> SOP (modes 0-2), PRE -> BIST (mode 3).
- SOP -> DATA (mode 0, paysize != 0); SOP -> CRC (mode 0, paysize == 0); SOP -> WAIT (modes 1/2).
- DATA: bit_idx counts 0..BYTE_BITS-1 on bit_tick. byte_cnt increments at bit_idx wrap. Exit to CRC on wrap when byte_cnt == paysize-1.
- txfifo_ld_en: pulses on the final SOP bit_tick (mode 0, paysize != 0), and on each DATA byte wrap except the last.
- Underrun: txfifo_ld_en=1 with txfifo_empty=1 sets the abort flag, pulses tx_und that cycle, and enters EOP next cycle (CRC skipped).
- tx_abort=1 in DATA or CRC sets the abort flag and enters EOP next cycle. It is ignored in PRE, SOP, EOP, WAIT and IDLE.
- CRC -> EOP; EOP -> WAIT.
- WAIT counts ifg_bits bit_ticks, then enters IDLE. ifg_bits=0 enters IDLE the cycle after WAIT entry.
- Completion pulse, registered, in the first IDLE cycle: tx_msg_sent (mode 0, no abort), tx_msg_abt (mode 0, abort), tx_rst_sent (modes 1/2). None for BIST.
- tx_start asserted while busy: ignored, not queued.
- bit_tick coincident with tx_start: no bit counted in IDLE. PRE count begins at the next tick.

Optional Feature:
Macro UCPD_TX_BIST_EN.
- Defined: mode 3 runs PRE then BIST for bist_bits ticks (bist_bits=0 leaves after one tick), then IDLE. tx_abort exits BIST to IDLE next cycle. No completion pulse.
- Undefined: BIST state and bist_en logic absent; bist_en tied 0; bist_bits unused; mode-3 start ignored, tx_busy stays 0.

Test Plan:
1. Mode 0, paysize=2, ifg_bits=25, FIFO full, bit_tick every 4 cycles -> PRE 64, SOP 20, DATA 20, CRC 40, EOP 5, WAIT 25 ticks. txfifo_ld_en exactly 2 pulses; tx_msg_sent once.
2. Mode 0, paysize=3, txfifo_empty=1 at the second ld_en -> tx_und pulse, CRC skipped, EOP 5 ticks, tx_msg_abt, no tx_msg_sent.
3. Mode 1 -> PRE 64, SOP 20, WAIT ifg_bits, tx_rst_sent; data_en never high, txfifo_ld_en never pulses.
4. Mode 0, tx_abort at CRC bit 10 -> EOP next cycle, tx_msg_abt. Repeat with tx_abort in PRE -> ignored, tx_msg_sent.
5. ucpden dropped during DATA -> IDLE next cycle, all outputs 0, no pulse. Re-enable plus tx_start -> clean full frame.
6. With UCPD_TX_BIST_EN, mode 3, bist_bits=100 -> bist_en for 100 ticks, then IDLE. Without the macro -> tx_busy stays 0.
